c3lib_rrarb_ctl: RTL and testbench

C3LIB_RRARB_CTL -- requirements
Module: c3lib_rrarb_ctl

---
 rtl/c3lib_rrarb_pkg.sv | 23 ++
 rtl/c3lib_rr_pick.sv | 43 ++++
 rtl/c3lib_rrarb_ctl.sv | 127 ++++++++++++
 tb/tb_c3lib_rrarb_ctl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/c3lib_rrarb_pkg.sv
// ============================================================================
// Module   : c3lib_rrarb_pkg
// Purpose  : Shared state encoding and index-width helper for the RR arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package c3lib_rrarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Index width for gnt_id/ptr; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/c3lib_rr_pick.sv
// ============================================================================
// Module   : c3lib_rr_pick
// Purpose  : Combinational round-robin picker: first request at/after ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module c3lib_rr_pick
    import c3lib_rrarb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      idx,
    output logic               any
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/c3lib_rrarb_ctl.sv
// ============================================================================
// Module   : c3lib_rrarb_ctl
// Purpose  : Round-robin ownership arbiter with break-before-make GAP cycle.
//            Optional hold timeout enabled by macro C3LIB_RRARB_TMO_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module c3lib_rrarb_ctl
    import c3lib_rrarb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             rel,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           gnt_vld,
    output logic [idx_width(NUM_REQ)-1:0]  gnt_id,
    output logic                           tmo_err
);

    localparam int IW = idx_width(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IW-1:0]      id_nxt;
    logic [IW-1:0]      ptr, ptr_nxt, ptr_inc;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               own_drop;
    logic               tmo_hit;

    c3lib_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // gnt is one-hot, so masking with it isolates the owner's bits.
    assign own_drop = !(|(req & gnt)) || (|(rel & gnt));
    assign ptr_inc  = (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

`ifdef C3LIB_RRARB_TMO_EN
    logic [7:0] hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            tmo_err  <= 1'b0;
        end else begin
            if (state != GRANT) begin
                hold_cnt <= '0;
            end else if (hold_cnt != 8'(MAX_HOLD)) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
            tmo_err <= tmo_hit && !own_drop;
        end
    end

    assign tmo_hit = (state == GRANT) && (hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign tmo_hit = 1'b0;
    // Legal MAX_HOLD (>= 1) folds this to a constant 0.
    assign tmo_err = (MAX_HOLD < 1);
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        ptr_nxt   = ptr;
        case (state)
            IDLE, GAP: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    gnt_nxt   = pick_onehot;
                    id_nxt    = pick_idx;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    id_nxt    = '0;
                end
            end
            GRANT: begin
                if (own_drop || tmo_hit) begin
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                    id_nxt    = '0;
                    ptr_nxt   = ptr_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                id_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_id  <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_vld <= |gnt_nxt;
            gnt_id  <= id_nxt;
            ptr     <= ptr_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_c3lib_rrarb_ctl.sv
// ============================================================================
// Module   : tb_c3lib_rrarb_ctl
// Purpose  : Scoreboard bench for c3lib_rrarb_ctl (NUM_REQ=4 and NUM_REQ=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_c3lib_rrarb_ctl;

    localparam int MH = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, rel;
    logic [3:0] gnt4;
    logic       vld4, tmo4;
    logic [1:0] id4;
    logic [0:0] gnt1, id1;
    logic       vld1, tmo1;

    c3lib_rrarb_ctl #(.NUM_REQ(4), .MAX_HOLD(MH)) dut4 (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .gnt(gnt4), .gnt_vld(vld4), .gnt_id(id4), .tmo_err(tmo4)
    );

    c3lib_rrarb_ctl #(.NUM_REQ(1), .MAX_HOLD(MH)) dut1 (
        .clk(clk), .rst(rst), .req(req[0:0]), .rel(rel[0:0]),
        .gnt(gnt1), .gnt_vld(vld1), .gnt_id(id1), .tmo_err(tmo1)
    );

    always #5 clk = ~clk;

    typedef struct { int owner; int ptr; int hold; } mstate_t;
    typedef struct { logic [7:0] d4; logic [3:0] d1; } exp_t;

    exp_t    q[$];
    mstate_t m4, m1;
    int      total, bad;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // One clock of the abstract arbiter: an owner either keeps the resource or
    // leaves it (next cycle is the gap); with no owner the arbiter picks.
    task automatic model_step(input int n, inout mstate_t s, input logic [3:0] rq,
                              input logic [3:0] rl, output logic tmo);
        logic leave, timeout;
        bit   found;
        tmo = 1'b0;
        if (s.owner >= 0) begin
            leave   = !rq[s.owner] || rl[s.owner];
            timeout = 1'b0;
`ifdef C3LIB_RRARB_TMO_EN
            timeout = (s.hold + 1 >= MH);
`endif
            if (leave || timeout) begin
                tmo     = !leave;
                s.ptr   = (s.owner + 1) % n;
                s.owner = -1;
            end else begin
                s.hold++;
            end
        end else begin
            found = 0;
            for (int k = 0; k < n; k++) begin
                int c;
                c = (s.ptr + k) % n;
                if (!found && rq[c]) begin
                    found   = 1;
                    s.owner = c;
                    s.hold  = 0;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] rq, input logic [3:0] rl);
        exp_t e;
        logic t4, t1;
        @(negedge clk);
        req = rq;
        rel = rl;
        if (r && !rst) begin
            rst = 1'b1;
            #1;
            chk("async_rst_dut4", {gnt4, vld4, id4}, 0);
            chk("async_rst_dut1", {gnt1, vld1, id1}, 0);
        end
        rst = r;
        if (r) begin
            m4 = '{-1, 0, 0};
            m1 = '{-1, 0, 0};
            t4 = 1'b0;
            t1 = 1'b0;
        end else begin
            model_step(4, m4, rq, rl, t4);
            model_step(1, m1, {3'b000, rq[0]}, {3'b000, rl[0]}, t1);
        end
        e.d4 = {(m4.owner >= 0) ? 4'(1 << m4.owner) : 4'd0, m4.owner >= 0,
                (m4.owner >= 0) ? 2'(m4.owner) : 2'd0, t4};
        e.d1 = {m1.owner >= 0, m1.owner >= 0, 1'b0, t1};
        q.push_back(e);
    endtask

    // Monitor: registered outputs are compared just after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("dut4{gnt,vld,id,tmo}", {gnt4, vld4, id4, tmo4}, e.d4);
                chk("dut1{gnt,vld,id,tmo}", {gnt1, vld1, id1, tmo1}, e.d1);
            end
        end
    end

    initial begin
        logic [3:0] rq, rl;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = '0;
        rel   = '0;
        m4    = '{-1, 0, 0};
        m1    = '{-1, 0, 0};

        repeat (3) cycle(1'b1, 4'b0000, 4'b0000);

        // Lone requester 2, then release.
        repeat (3) cycle(1'b0, 4'b0100, 4'b0000);
        cycle(1'b0, 4'b0100, 4'b0100);
        repeat (3) cycle(1'b0, 4'b0000, 4'b0000);

        // Everyone requesting; each owner releases after two grant cycles.
        repeat (24) begin
            rl = (m4.owner >= 0 && m4.hold >= 1) ? 4'(1 << m4.owner) : 4'b0000;
            cycle(1'b0, 4'b1111, rl);
        end
        repeat (2) cycle(1'b0, 4'b0000, 4'b0000);

        // Non-owner release pulses must be ignored.
        repeat (2) cycle(1'b0, 4'b0010, 4'b0000);
        repeat (3) cycle(1'b0, 4'b0010, 4'b1000);
        cycle(1'b0, 4'b0010, 4'b0010);
        repeat (2) cycle(1'b0, 4'b0000, 4'b0000);

        // Hold with no release (timeout when enabled), then release on the last cycle.
        repeat (10) cycle(1'b0, 4'b0010, 4'b0000);
        repeat (10) begin
            rl = (m4.owner == 1 && m4.hold == MH - 1) ? 4'b0010 : 4'b0000;
            cycle(1'b0, 4'b0010, rl);
        end
        repeat (2) cycle(1'b0, 4'b0000, 4'b0000);

        // Reset while requester 2 owns; restart must begin from ptr 0.
        repeat (3) cycle(1'b0, 4'b0100, 4'b0000);
        cycle(1'b1, 4'b0100, 4'b0000);
        cycle(1'b1, 4'b0110, 4'b0000);
        repeat (3) cycle(1'b0, 4'b0110, 4'b0000);
        repeat (2) cycle(1'b0, 4'b0000, 4'b0000);

        // Single-bit requester held with periodic release.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 4'b0001, (i % 3 == 2) ? 4'b0001 : 4'b0000);
        end

        // Random traffic with sticky requests and rare resets.
        rq = 4'b0000;
        repeat (600) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            rl = 4'($urandom) & 4'($urandom) & 4'($urandom);
            cycle($urandom_range(0, 99) == 0, rq, rl);
        end
        cycle(1'b0, 4'b0000, 4'b0000);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
